// File: rtl/cmpx_mac_pkg.sv
// Shared types and constants for the complex MAC initiator.
// Field positions follow the {re, im} packing used on both sides of the multiplier.
package cmpx_mac_pkg;

  localparam int ACC_W_DEF     = 12;
  localparam int N_SAMPLES_DEF = 4;

  localparam int RE_NIB_HI  = 7;
  localparam int RE_NIB_LO  = 4;
  localparam int IM_NIB_HI  = 3;
  localparam int IM_NIB_LO  = 0;

  localparam int RE_BYTE_HI = 15;
  localparam int RE_BYTE_LO = 8;
  localparam int IM_BYTE_HI = 7;
  localparam int IM_BYTE_LO = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LO,
    S_WAIT_HI,
    S_ACCUM,
    S_DONE
  } state_t;

endpackage

// File: rtl/cmpx_acc_add.sv
// Signed accumulate of one sign-extended 8-bit product component.
// CMPX_MAC_SAT_EN selects sticky saturation; otherwise the sum wraps.
module cmpx_acc_add
  import cmpx_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [7:0]       i_prod,
  input  logic             i_hold,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_sat
);

  logic [ACC_W:0] w_ext;

  assign w_ext = {i_acc[ACC_W-1], i_acc}
               + {{(ACC_W-7){i_prod[7]}}, i_prod};

`ifdef CMPX_MAC_SAT_EN
  logic w_ovf;

  assign w_ovf = w_ext[ACC_W] ^ w_ext[ACC_W-1];

  // once clamped, the component is frozen until the frame clears it
  always_comb begin
    o_sum = w_ext[ACC_W-1:0];
    o_sat = i_hold | w_ovf;
    if (i_hold) begin
      o_sum = i_acc;
    end else if (w_ovf) begin
      o_sum = w_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                           : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  logic w_unused;

  assign w_unused = i_hold ^ w_ext[ACC_W];
  assign o_sum    = w_ext[ACC_W-1:0];
  assign o_sat    = 1'b0;
`endif

endmodule

// File: rtl/cmpx_mac_initiator.sv
// Issues complex operand pairs to the multiplier and sums N_SAMPLES products.
// Optional feature macro: CMPX_MAC_SAT_EN (saturating accumulate).
module cmpx_mac_initiator
  import cmpx_mac_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             mul_start,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic             mul_done,
  input  logic [15:0]      mul_out,
  output logic [ACC_W-1:0] acc_re,
  output logic [ACC_W-1:0] acc_im,
  output logic             acc_valid,
  output logic             busy
);

  localparam int CNT_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

  state_t r_state, w_next;

  logic [7:0]       r_a, r_b;
  logic [15:0]      r_prod;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_int_re, r_int_im;
  logic [ACC_W-1:0] r_acc_re, r_acc_im;
  logic             r_sat_re, r_sat_im;

  logic [ACC_W-1:0] w_sum_re, w_sum_im;
  logic             w_sat_re, w_sat_im;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(N_SAMPLES - 1));

  cmpx_acc_add #(.ACC_W(ACC_W)) u_add_re (
    .i_acc  (r_int_re),
    .i_prod (r_prod[RE_BYTE_HI:RE_BYTE_LO]),
    .i_hold (r_sat_re),
    .o_sum  (w_sum_re),
    .o_sat  (w_sat_re)
  );

  cmpx_acc_add #(.ACC_W(ACC_W)) u_add_im (
    .i_acc  (r_int_im),
    .i_prod (r_prod[IM_BYTE_HI:IM_BYTE_LO]),
    .i_hold (r_sat_im),
    .o_sum  (w_sum_im),
    .o_sat  (w_sat_im)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_int_re <= '0;
      r_int_im <= '0;
      r_acc_re <= '0;
      r_acc_im <= '0;
      r_sat_re <= 1'b0;
      r_sat_im <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid) begin
        r_a <= {in_a[RE_NIB_HI:RE_NIB_LO], in_a[IM_NIB_HI:IM_NIB_LO]};
        r_b <= {in_b[RE_NIB_HI:RE_NIB_LO], in_b[IM_NIB_HI:IM_NIB_LO]};
      end
      if (r_state == S_WAIT_HI && mul_done) begin
        r_prod <= mul_out;
      end
      if (r_state == S_ACCUM) begin
        r_int_re <= w_sum_re;
        r_int_im <= w_sum_im;
        r_sat_re <= w_sat_re;
        r_sat_im <= w_sat_im;
        // result registers load here so they are valid during DONE
        if (w_last) begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (r_state == S_DONE) begin
        r_int_re <= '0;
        r_int_im <= '0;
        r_sat_re <= 1'b0;
        r_sat_im <= 1'b0;
        r_cnt    <= '0;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    acc_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mul_start = 1'b1;
        w_next    = S_WAIT_LO;
      end
      // a done level left over from the previous product must clear first
      S_WAIT_LO: if (!mul_done) w_next = S_WAIT_HI;
      S_WAIT_HI: if (mul_done)  w_next = S_ACCUM;
      S_ACCUM:   w_next = w_last ? S_DONE : S_IDLE;
      S_DONE: begin
        acc_valid = 1'b1;
        w_next    = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  assign mul_a  = r_a;
  assign mul_b  = r_b;
  assign acc_re = r_acc_re;
  assign acc_im = r_acc_im;
  assign busy   = (r_state != S_IDLE) || (r_cnt != '0);

endmodule

// File: tb/tb_cmpx_mac_initiator.sv
// Bench for cmpx_mac_initiator: three configurations share one clock and a
// behavioural latency-6 complex multiplier per instance.
module tb_cmpx_mac_initiator;

  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst;

  logic        in_valid  [3];
  logic [7:0]  in_a      [3];
  logic [7:0]  in_b      [3];
  logic        in_ready  [3];
  logic        mul_start [3];
  logic [7:0]  mul_a     [3];
  logic [7:0]  mul_b     [3];
  logic        mul_done  [3];
  logic [15:0] mul_out   [3];
  logic        acc_valid [3];
  logic        busy      [3];
  int          acc_re_i  [3];
  int          acc_im_i  [3];

  logic        hold   [3];
  logic        done_r [3];
  int          cnt_m  [3];
  logic [15:0] pend   [3];

  int nval    [3] = '{0, 0, 0};
  int last_re [3] = '{0, 0, 0};
  int last_im [3] = '{0, 0, 0};

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         re;
    int         im;
  } vec_t;

  vec_t tbl[7];

  initial forever #5 clk = ~clk;

  // instance 0: N=3 W=12, instance 1: N=1 W=12, instance 2: N=4 W=8
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NS = (g == 0) ? 3 : (g == 1) ? 1 : 4;
    localparam int AW = (g == 2) ? 8 : 12;
    logic [AW-1:0] w_re, w_im;
    cmpx_mac_initiator #(.N_SAMPLES(NS), .ACC_W(AW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_a      (in_a[g]),
      .in_b      (in_b[g]),
      .mul_start (mul_start[g]),
      .mul_a     (mul_a[g]),
      .mul_b     (mul_b[g]),
      .mul_done  (mul_done[g]),
      .mul_out   (mul_out[g]),
      .acc_re    (w_re),
      .acc_im    (w_im),
      .acc_valid (acc_valid[g]),
      .busy      (busy[g])
    );
    assign acc_re_i[g] = int'($signed(w_re));
    assign acc_im_i[g] = int'($signed(w_im));
  end

  function automatic logic [7:0] cx(int re, int im);
    return {re[3:0], im[3:0]};
  endfunction

  function automatic int p_re(logic [7:0] a, logic [7:0] b);
    int ar = int'($signed(a[7:4]));
    int ai = int'($signed(a[3:0]));
    int br = int'($signed(b[7:4]));
    int bi = int'($signed(b[3:0]));
    return ar * br - ai * bi;
  endfunction

  function automatic int p_im(logic [7:0] a, logic [7:0] b);
    int ar = int'($signed(a[7:4]));
    int ai = int'($signed(a[3:0]));
    int br = int'($signed(b[7:4]));
    int bi = int'($signed(b[3:0]));
    return ar * bi + ai * br;
  endfunction

  function automatic logic [15:0] cmul(logic [7:0] a, logic [7:0] b);
    int re = p_re(a, b);
    int im = p_im(a, b);
    return {re[7:0], im[7:0]};
  endfunction

  function automatic int wrap(int v, int w);
    int m = 1 << w;
    int r = ((v % m) + m) % m;
    return (r >= m / 2) ? r - m : r;
  endfunction

  // behavioural multiplier: done is a level, dropped by the next start
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 3; g++) begin
        done_r[g]  <= 1'b0;
        cnt_m[g]   <= 0;
        pend[g]    <= '0;
        mul_out[g] <= '0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (mul_start[g]) begin
          cnt_m[g]  <= LAT;
          done_r[g] <= 1'b0;
          pend[g]   <= cmul(mul_a[g], mul_b[g]);
        end else if (cnt_m[g] > 0) begin
          cnt_m[g] <= cnt_m[g] - 1;
          if (cnt_m[g] == 1) begin
            done_r[g]  <= 1'b1;
            mul_out[g] <= pend[g];
          end
        end
      end
    end
  end

  always_comb
    for (int g = 0; g < 3; g++) mul_done[g] = done_r[g] | hold[g];

  always @(negedge clk)
    for (int g = 0; g < 3; g++)
      if (acc_valid[g] === 1'b1) begin
        nval[g]    = nval[g] + 1;
        last_re[g] = acc_re_i[g];
        last_im[g] = acc_im_i[g];
      end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic send(int g, logic [7:0] a, logic [7:0] b);
    int t = 0;
    while (in_ready[g] !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_send", int'(in_ready[g] === 1'b1), 1);
    in_valid[g] = 1'b1;
    in_a[g]     = a;
    in_b[g]     = b;
    @(negedge clk);
    in_valid[g] = 1'b0;
    chk("start_after_accept", int'(mul_start[g]), 1);
    chk("mul_a_issued", int'(mul_a[g]), int'(a));
  endtask

  // follows one product from done rise through ACCUM
  task automatic track(int g, bit last);
    int t = 0;
    while (mul_done[g] !== 1'b0 && t < 50) begin @(negedge clk); t++; end
    while (mul_done[g] !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    chk("done_rise_seen", int'(t < 50), 1);
    @(negedge clk);
    chk("ready_low_in_accum", int'(in_ready[g]), 0);
    @(negedge clk);
    if (last) chk("valid_after_accum", int'(acc_valid[g]), 1);
    else      chk("ready_after_accum", int'(in_ready[g]), 1);
  endtask

  task automatic wait_results(int g, int target);
    int t = 0;
    while (nval[g] < target && t < 300) begin @(negedge clk); t++; end
    chk("result_arrived", int'(nval[g] >= target), 1);
  endtask

  initial begin
    int n0, sre, sim, ere;
    logic [7:0] ra, rb;
    bit sat;

    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g] = 1'b0;
      in_a[g]     = '0;
      in_b[g]     = '0;
      hold[g]     = 1'b0;
    end
    tbl[0] = '{cx(2, 2),  cx(1, 2),  -2,  6};
    tbl[1] = '{cx(2, 3),  cx(2, 1),   1,  8};
    tbl[2] = '{cx(1, 0),  cx(1, 3),   1,  3};
    tbl[3] = '{cx(-1, -1), cx(-1, 1), 2,  0};
    tbl[4] = '{cx(7, 7),  cx(7, -7), 98,  0};
    tbl[5] = '{cx(-7, 0), cx(7, 0), -49,  0};
    tbl[6] = '{cx(3, -2), cx(0, 5),  10, 15};

    tick(3);
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", int'(in_ready[g]), 1);
      chk("rst_mul_start", int'(mul_start[g]), 0);
      chk("rst_mul_ab", int'({mul_a[g], mul_b[g]}), 0);
      chk("rst_acc_re", acc_re_i[g], 0);
      chk("rst_acc_im", acc_im_i[g], 0);
      chk("rst_acc_valid", int'(acc_valid[g]), 0);
      chk("rst_busy", int'(busy[g]), 0);
    end
    rst = 1'b0;
    tick(1);

    // N=3 frame with handshake timing
    n0 = nval[0];
    send(0, cx(2, 3), cx(2, 1)); track(0, 0);
    chk("busy_mid_frame", int'(busy[0]), 1);
    send(0, cx(2, 2), cx(1, 2)); track(0, 0);
    send(0, cx(1, 0), cx(1, 3)); track(0, 1);
    wait_results(0, n0 + 1);
    tick(10);
    chk("n3_pulses", nval[0] - n0, 1);
    chk("n3_re", last_re[0], 0);
    chk("n3_im", last_im[0], 17);
    chk("n3_held_re", acc_re_i[0], 0);
    chk("n3_held_im", acc_im_i[0], 17);

    // N=1 table
    for (int i = 0; i < 7; i++) begin
      n0 = nval[1];
      send(1, tbl[i].a, tbl[i].b);
      wait_results(1, n0 + 1);
      chk("tbl_re", last_re[1], tbl[i].re);
      chk("tbl_im", last_im[1], tbl[i].im);
    end

    // N=1 with in_valid held across two pairs
    n0 = nval[1];
    in_valid[1] = 1'b1;
    in_a[1] = cx(2, 2);
    in_b[1] = cx(1, 2);
    @(negedge clk);
    chk("held_start_a", int'(mul_start[1]), 1);
    in_a[1] = cx(1, 0);
    in_b[1] = cx(1, 3);
    wait_results(1, n0 + 1);
    chk("held_a_re", last_re[1], -2);
    chk("held_a_im", last_im[1], 6);
    begin
      int t = 0;
      while (in_ready[1] !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    end
    @(negedge clk);
    in_valid[1] = 1'b0;
    chk("held_start_b", int'(mul_start[1]), 1);
    chk("held_mul_a_b", int'(mul_a[1]), int'(cx(1, 0)));
    wait_results(1, n0 + 2);
    tick(8);
    chk("held_pulses", nval[1] - n0, 2);
    chk("held_b_re", last_re[1], 1);
    chk("held_b_im", last_im[1], 3);

    // done held from before start, released two cycles after the pulse
    hold[1] = 1'b1;
    n0 = nval[1];
    send(1, cx(3, -2), cx(0, 5));
    tick(2);
    chk("hold_busy", int'(busy[1]), 1);
    chk("hold_no_early", nval[1] - n0, 0);
    hold[1] = 1'b0;
    wait_results(1, n0 + 1);
    tick(15);
    chk("hold_one_capture", nval[1] - n0, 1);
    chk("hold_re", last_re[1], 10);
    chk("hold_im", last_im[1], 15);

    // ACC_W=8 overflow
    n0 = nval[2];
    for (int i = 0; i < 4; i++) send(2, cx(7, 0), cx(7, 0));
    wait_results(2, n0 + 1);
    sre = 0;
    sat = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef CMPX_MAC_SAT_EN
      if (!sat) begin
        sre = sre + 49;
        if (sre > 127) begin sre = 127; sat = 1'b1; end
      end
`else
      sre = wrap(sre + 49, 8);
`endif
    end
    chk("w8_re", last_re[2], sre);
    chk("w8_im", last_im[2], 0);

    // in_valid pulsed during WAIT_HI
    n0 = nval[0];
    send(0, cx(2, 3), cx(2, 1));
    tick(2);
    in_valid[0] = 1'b1;
    in_a[0] = cx(7, 7);
    in_b[0] = cx(7, 7);
    chk("waithi_ready_low", int'(in_ready[0]), 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("waithi_no_start", int'(mul_start[0]), 0);
    chk("waithi_mul_a", int'(mul_a[0]), int'(cx(2, 3)));
    send(0, cx(2, 2), cx(1, 2));
    send(0, cx(1, 0), cx(1, 3));
    wait_results(0, n0 + 1);
    chk("waithi_re", last_re[0], 0);
    chk("waithi_im", last_im[0], 17);

    // reset in WAIT_HI of the second sample
    send(0, cx(7, 7), cx(7, -7));
    track(0, 0);
    send(0, cx(-7, 0), cx(7, 0));
    tick(2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", int'(in_ready[0]), 1);
    chk("mid_rst_busy", int'(busy[0]), 0);
    chk("mid_rst_ab", int'({mul_a[0], mul_b[0]}), 0);
    chk("mid_rst_acc", acc_re_i[0] | acc_im_i[0], 0);
    rst = 1'b0;
    n0 = nval[0];
    send(0, cx(1, 1), cx(1, 1));
    send(0, cx(3, 0), cx(2, 0));
    send(0, cx(0, 1), cx(0, 1));
    wait_results(0, n0 + 1);
    chk("post_rst_re", last_re[0], 5);
    chk("post_rst_im", last_im[0], 2);

    // random frames against plain arithmetic
    for (int f = 0; f < 8; f++) begin
      n0 = nval[0];
      sre = 0;
      sim = 0;
      for (int k = 0; k < 3; k++) begin
        ra = cx(int'($urandom_range(14, 0)) - 7, int'($urandom_range(14, 0)) - 7);
        rb = cx(int'($urandom_range(14, 0)) - 7, int'($urandom_range(14, 0)) - 7);
        sre += p_re(ra, rb);
        sim += p_im(ra, rb);
        send(0, ra, rb);
      end
      wait_results(0, n0 + 1);
      tick(4);
      chk("rand_pulses", nval[0] - n0, 1);
      chk("rand_re", last_re[0], wrap(sre, 12));
      chk("rand_im", last_im[0], wrap(sim, 12));
    end

    // done stuck high: block waits until reset
    hold[1] = 1'b1;
    n0 = nval[1];
    send(1, cx(2, 2), cx(2, 2));
    tick(30);
    chk("stuck_busy", int'(busy[1]), 1);
    chk("stuck_ready", int'(in_ready[1]), 0);
    chk("stuck_no_result", nval[1] - n0, 0);
    do_reset();
    hold[1] = 1'b0;
    tick(1);
    chk("stuck_rst_ready", int'(in_ready[1]), 1);
    ere = acc_re_i[1];
    chk("stuck_rst_acc", ere, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
